// File: rtl/dac_spi_pkg.sv
// Shared types and frame constants for the quad 12-bit SPI DAC writer.
// Frame layout, MSB first: [15:14] channel, [13:12] mode, [11:0] code.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LDAC  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int CH_W    = 2;
  localparam int MODE_W  = 2;
  localparam int CODE_W  = 12;
  localparam int FRAME_W = 16;

  localparam int CODE_POS = 0;
  localparam int MODE_POS = CODE_POS + CODE_W;
  localparam int CH_POS   = MODE_POS + MODE_W;

  // Write input register only (update deferred to LDAC).
  localparam logic [MODE_W-1:0] MODE_WR    = 2'b00;
  // Write input register and update the output immediately.
  localparam logic [MODE_W-1:0] MODE_WRUPD = 2'b01;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [CH_W-1:0]   ch,
    input logic [MODE_W-1:0] mode,
    input logic [CODE_W-1:0] code
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[CH_POS +: CH_W]     = ch;
    f[MODE_POS +: MODE_W] = mode;
    f[CODE_POS +: CODE_W] = code;
    return f;
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SCLK generator: half-period counter running while enabled, registered
// SCLK level (idle high) and strobes that announce the SCLK edge taking
// effect on the next clock edge. Disabling parks SCLK high.
module dac_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  logic [7:0] r_cnt;
  logic       r_sclk;
  logic       w_tick;

  assign w_tick = i_en && (r_cnt == 8'(CLK_DIV - 1));
  assign o_rise = w_tick && !r_sclk;
  assign o_fall = w_tick && r_sclk;
  assign o_sclk = r_sclk;

  // Half-period counter and SCLK toggle; parked high when not enabled.
  always_ff @(posedge i_clk) begin
    if (i_srst || !i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dac_spi_write.sv
// Serial write controller for a quad 12-bit SPI DAC (16-bit frame).
// Optional feature macro: DAC_LDAC_EN -- builds the LDAC pulse state and
// counter and switches the frame mode to "write input register only".
module dac_spi_write
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int GAP_CYC  = 4,
  parameter int LDAC_CYC = 2
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_ldac,
  output logic              busy,
  output logic              done,
  output logic              DAC_SYNC,
  output logic              DAC_SCLK,
  output logic              DAC_DIN,
  output logic              DAC_LDAC
);

  state_t               r_state;
  state_t               w_state_next;
  logic [FRAME_W-1:0]   r_shift;
  logic [3:0]           r_bit;
  logic                 r_last_fall;
  logic [7:0]           r_gap_cnt;
  logic                 r_sync;
  logic                 r_done;
  logic                 w_accept;
  logic                 w_frame_end;
  logic                 w_sclk_en;
  logic                 w_rise;
  logic                 w_fall;
  logic [MODE_W-1:0]    w_mode;

`ifdef DAC_LDAC_EN
  logic                 r_ldac_req;
  logic [7:0]           r_ldac_cnt;
  logic                 r_ldac_n;
  assign w_mode = MODE_WR;
`else
  logic                 w_unused;
  assign w_mode   = MODE_WRUPD;
  assign w_unused = in_ldac ^ (LDAC_CYC == 0);
`endif

  assign w_accept    = in_valid && (r_state == IDLE);
  // The frame ends on the SCLK rise that follows the 16th falling edge.
  assign w_frame_end = (r_state == SHIFT) && w_rise && r_last_fall;

  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign DAC_SYNC = r_sync;
  assign DAC_DIN  = r_shift[FRAME_W-1];

  dac_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .i_clk (sys_clk),
    .i_srst(rst),
    .i_en  (w_sclk_en),
    .o_sclk(DAC_SCLK),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next-state and SCLK enable.
  always_comb begin
    w_state_next = r_state;
    w_sclk_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = SHIFT;
      end
      SHIFT: begin
        w_sclk_en = 1'b1;
        if (w_frame_end) begin
`ifdef DAC_LDAC_EN
          w_state_next = r_ldac_req ? LDAC : GAP;
`else
          w_state_next = GAP;
`endif
        end
      end
`ifdef DAC_LDAC_EN
      LDAC: begin
        if (r_ldac_cnt == 8'(LDAC_CYC)) w_state_next = GAP;
      end
`endif
      GAP: begin
        if (r_gap_cnt == 8'(GAP_CYC - 1)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Shift register, bit counter, SYNC and done pulse.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_bit       <= '0;
      r_last_fall <= 1'b0;
      r_sync      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_sync <= (w_state_next != SHIFT);
      r_done <= w_frame_end;
      if (w_accept) begin
        r_shift     <= build_frame(in_ch, w_mode, in_code);
        r_bit       <= '0;
        r_last_fall <= 1'b0;
      end else if (r_state == SHIFT) begin
        // DIN moves to the next bit on every SCLK rise; zeros fill behind.
        if (w_rise) begin
          r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
          r_bit   <= r_bit + 4'd1;
        end
        if (w_fall && (r_bit == 4'd15)) r_last_fall <= 1'b1;
      end
    end
  end

  // Inter-frame gap counter, cleared outside GAP.
  always_ff @(posedge sys_clk) begin
    if (rst || (r_state != GAP)) r_gap_cnt <= '0;
    else                         r_gap_cnt <= r_gap_cnt + 8'd1;
  end

`ifdef DAC_LDAC_EN
  // LDAC request latch, LDAC counter and registered active-low strobe.
  // The first LDAC-state cycle keeps the pin high so the pulse starts
  // one cycle after SYNC rises.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_ldac_req <= 1'b0;
      r_ldac_cnt <= '0;
      r_ldac_n   <= 1'b1;
    end else begin
      if (w_accept) r_ldac_req <= in_ldac;
      if (r_state != LDAC) r_ldac_cnt <= '0;
      else                 r_ldac_cnt <= r_ldac_cnt + 8'd1;
      r_ldac_n <= !((r_state == LDAC) && (r_ldac_cnt < 8'(LDAC_CYC)));
    end
  end
  assign DAC_LDAC = r_ldac_n;
`else
  assign DAC_LDAC = 1'b1;
`endif

endmodule

// File: tb/tb_dac_spi_write.sv
// Bench for dac_spi_write: instance 0 uses default timing, instance 1 uses
// CLK_DIV=1/GAP_CYC=1. Expected frames are queued at accept and compared
// by per-instance monitors when the DUT signals done.
module tb_dac_spi_write;

  localparam int LDAC_CYC = 2;
`ifdef DAC_LDAC_EN
  localparam logic [1:0] EXP_MODE = 2'b00;
  localparam bit         LDAC_ON  = 1'b1;
`else
  localparam logic [1:0] EXP_MODE = 2'b01;
  localparam bit         LDAC_ON  = 1'b0;
`endif

  typedef struct {
    logic [15:0] frame;
    bit          ldac;
  } exp_t;

  exp_t exp_q[$];

  logic        clk;
  logic        rst;
  logic        vld     [2];
  logic [1:0]  ch;
  logic [11:0] code;
  logic        ldac_req;
  logic        rdy_w   [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic        sync_w  [2];
  logic        sclk_w  [2];
  logic        din_w   [2];
  logic        ldac_w  [2];

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_done   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dac_spi_write #(.CLK_DIV(2), .GAP_CYC(4), .LDAC_CYC(LDAC_CYC)) u_dut_a (
    .sys_clk(clk), .rst(rst),
    .in_valid(vld[0]), .in_ready(rdy_w[0]),
    .in_ch(ch), .in_code(code), .in_ldac(ldac_req),
    .busy(busy_w[0]), .done(done_w[0]),
    .DAC_SYNC(sync_w[0]), .DAC_SCLK(sclk_w[0]),
    .DAC_DIN(din_w[0]), .DAC_LDAC(ldac_w[0])
  );

  dac_spi_write #(.CLK_DIV(1), .GAP_CYC(1), .LDAC_CYC(LDAC_CYC)) u_dut_b (
    .sys_clk(clk), .rst(rst),
    .in_valid(vld[1]), .in_ready(rdy_w[1]),
    .in_ch(ch), .in_code(code), .in_ldac(ldac_req),
    .busy(busy_w[1]), .done(done_w[1]),
    .DAC_SYNC(sync_w[1]), .DAC_SCLK(sclk_w[1]),
    .DAC_DIN(din_w[1]), .DAC_LDAC(ldac_w[1])
  );

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Monitors: one per instance, sampling on the falling system-clock edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    localparam int D = (gi == 0) ? 2 : 1;
    localparam int G = (gi == 0) ? 4 : 1;
    bit          active     = 1'b0;
    bit          after_done = 1'b0;
    int          cyc        = 0;
    int          nfall      = 0;
    int          sync_lo    = 0;
    int          sync_first = -1;
    int          ldac_lo    = 0;
    int          ldac_first = -1;
    logic [15:0] shreg      = '0;
    logic        sclk_prev  = 1'b1;
    exp_t        cur;

    always @(negedge clk) begin
      if (rst) begin
        active     = 1'b0;
        after_done = 1'b0;
        sclk_prev  = 1'b1;
      end else begin
        if (active) begin
          cyc++;
          if (!ldac_w[gi]) begin
            ldac_lo++;
            if (ldac_first < 0) ldac_first = cyc;
          end
          if (!after_done) begin
            if (cyc == 1) begin
              check("busy_in_frame", busy_w[gi], 1);
              check("ready_in_frame", rdy_w[gi], 0);
            end
            if (!sync_w[gi]) begin
              sync_lo++;
              if (sync_first < 0) sync_first = cyc;
            end
            if (sclk_prev && !sclk_w[gi]) begin
              check("fall_cyc", cyc, 1 + D + 2 * nfall * D);
              shreg = {shreg[14:0], din_w[gi]};
              nfall++;
            end
            if (done_w[gi]) begin
              check("queue_nonempty", int'(exp_q.size() > 0), 1);
              if (exp_q.size() > 0) cur = exp_q.pop_front();
              else cur = '{frame: 16'h0, ldac: 1'b0};
              check("frame", shreg, cur.frame);
              check("nfall", nfall, 16);
              check("done_cyc", cyc, 1 + 32 * D);
              check("sync_first", sync_first, 1);
              check("sync_low", sync_lo, 32 * D);
              check("sclk_at_done", sclk_w[gi], 1);
              n_done++;
              after_done = 1'b1;
              $display("inst %0d: frame 0x%04h ldac=%0d done at cycle %0d",
                       gi, shreg, cur.ldac, cyc);
            end
          end else begin
            check("done_width", done_w[gi], 0);
            if (rdy_w[gi]) begin
              check("ready_cyc", cyc, 1 + 32 * D + G + (cur.ldac ? LDAC_CYC + 1 : 0));
              check("ldac_low", ldac_lo, cur.ldac ? LDAC_CYC : 0);
              check("ldac_first", ldac_first, cur.ldac ? 2 + 32 * D : -1);
              check("busy_at_ready", busy_w[gi], 0);
              active = 1'b0;
            end
          end
        end
        if (vld[gi] && rdy_w[gi]) begin
          active     = 1'b1;
          after_done = 1'b0;
          cyc        = 0;
          nfall      = 0;
          sync_lo    = 0;
          sync_first = -1;
          ldac_lo    = 0;
          ldac_first = -1;
          shreg      = '0;
        end
        sclk_prev = sclk_w[gi];
      end
    end
  end

  task automatic send(input int inst, input logic [1:0] c, input logic [11:0] k,
                      input logic l, input bit push);
    int n;
    n = 0;
    while (!rdy_w[inst] && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", int'(n >= 1000), 0);
    ch = c; code = k; ldac_req = l; vld[inst] = 1'b1;
    if (push) begin
      exp_q.push_back('{frame: {c, EXP_MODE, k}, ldac: l & LDAC_ON});
      n_push++;
    end
    @(posedge clk); #1;
    vld[inst] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && rdy_w[0] && rdy_w[1]) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", int'(n >= 3000), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; vld[0] = 1'b0; vld[1] = 1'b0;
    ch = '0; code = '0; ldac_req = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_sync", sync_w[i], 1);
      check("rst_sclk", sclk_w[i], 1);
      check("rst_din", din_w[i], 0);
      check("rst_ldac", ldac_w[i], 1);
      check("rst_ready", rdy_w[i], 1);
      check("rst_busy", busy_w[i], 0);
      check("rst_done", done_w[i], 0);
    end

    // Single frame, default timing.
    send(0, 2'd2, 12'hA5C, 1'b0, 1'b1);
    wait_idle();

    // Fast instance, back-to-back frames.
    send(1, 2'd3, 12'h123, 1'b0, 1'b1);
    send(1, 2'd0, 12'hFFF, 1'b0, 1'b1);
    send(1, 2'd1, 12'h000, 1'b0, 1'b1);
    wait_idle();

    // LDAC requested and not requested.
    send(0, 2'd1, 12'hFFF, 1'b1, 1'b1);
    wait_idle();
    send(0, 2'd1, 12'hFFF, 1'b0, 1'b1);
    wait_idle();
    send(1, 2'd2, 12'h8F1, 1'b1, 1'b1);
    wait_idle();

    // in_valid held high with changing payload: one frame per accept.
    for (int c = 0; c < 200; c++) begin
      vld[0] = 1'b1;
      ch = 2'(c % 4);
      code = 12'($urandom);
      ldac_req = 1'b0;
      if (rdy_w[0]) begin
        exp_q.push_back('{frame: {ch, EXP_MODE, code}, ldac: 1'b0});
        n_push++;
      end
      @(posedge clk); #1;
    end
    vld[0] = 1'b0;
    wait_idle();

    // Reset at cycle 20 of a frame, then a fresh frame.
    send(0, 2'd2, 12'h3C3, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_sync", sync_w[0], 1);
    check("midrst_sclk", sclk_w[0], 1);
    check("midrst_busy", busy_w[0], 0);
    check("midrst_din", din_w[0], 0);
    check("midrst_ready", rdy_w[0], 1);
    rst = 1'b0;
    @(posedge clk); #1;
    send(0, 2'd3, 12'h5A3, 1'b0, 1'b1);
    wait_idle();

    check("queue_drained", exp_q.size(), 0);
    check("frames_done", n_done, n_push);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
